lfsr_stim_gen: RTL and testbench

- Parametrised pseudo-random stimulus generator for the LUT-split DA datapath.
- Produces address vectors for `N_CH` LUT channels and one shared weight vector `B_temp`, from two independent LFSRs of configurable width.
- Adds over the previous generator:
  - a valid/ready output handshake
  - runtime-loadable seeds
  - run-length control
  - weight refresh counted in accepted address vectors rather than raw cycles
- Sits between the testbench/controller and the LUT-split array inputs.

---
 rtl/lfsr_stim_gen.sv | 231 +++++++++++++++++++++++
 tb/tb_lfsr_stim_gen.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/lfsr_stim_gen.sv
// lfsr_stim_gen: pseudo-random address/weight stimulus for the LUT-split DA array.
// Two Fibonacci LFSRs (address, weight) feed a valid/ready output stage.
// A run is started and stopped from IDLE/RUN control inputs.
// Optional feature: define LFSR_STIM_GEN_CHKSUM_EN to enable the running address checksum.
module lfsr_stim_gen #(
    parameter int K                  = 8,
    parameter int DATA_WIDTH_B       = 8,
    parameter int N_CH               = 2,
    parameter int LFSR_W             = 16,
    parameter int ADDR_UPDATE_PERIOD = 1,
    parameter int B_UPDATE_PERIOD    = 16,
    parameter logic [LFSR_W-1:0] SEED_ADDR_DEF = LFSR_W'('hD348),
    parameter logic [LFSR_W-1:0] SEED_B_DEF    = LFSR_W'('hA562)
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic                                start,
    input  logic                                stop,
    input  logic [15:0]                         num_vectors,
    input  logic                                seed_load,
    input  logic [LFSR_W-1:0]                   seed_addr,
    input  logic [LFSR_W-1:0]                   seed_b,
    output logic                                out_valid,
    input  logic                                out_ready,
    output logic [N_CH-1:0][K-2:0]              addr_array,
    output logic signed [K-1:0][DATA_WIDTH_B-1:0] B_temp,
    output logic                                update_pulse_b,
    output logic                                busy,
    output logic                                done,
    output logic [15:0]                         vec_count,
    output logic [31:0]                         checksum
);

    // Tap positions below the MSB; indices kept in range for both widths.
    localparam int T1 = (LFSR_W == 32) ? 21 : 13;
    localparam int T2 = (LFSR_W == 32) ? 1  : 12;
    localparam int T3 = (LFSR_W == 32) ? 0  : 10;

    // Gap counter reload leaves out_valid low for P-1 cycles after an accept.
    localparam int GAP_W = $clog2(ADDR_UPDATE_PERIOD + 1);
    localparam logic [GAP_W-1:0] GAP_RELOAD =
        GAP_W'((ADDR_UPDATE_PERIOD >= 2) ? ADDR_UPDATE_PERIOD - 2 : 0);
    localparam int BW = $clog2(B_UPDATE_PERIOD + 1);
    localparam logic [BW-1:0] B_PERIOD = BW'(B_UPDATE_PERIOD);

    typedef enum logic {S_IDLE, S_RUN} state_t;

    function automatic logic [LFSR_W-1:0] lfsr_step(input logic [LFSR_W-1:0] s);
        logic fb;
        fb = s[LFSR_W-1] ^ s[T1] ^ s[T2] ^ s[T3];
        return {s[LFSR_W-2:0], fb};
    endfunction

    state_t                         state_q, state_d;
    logic                           valid_q, valid_d;
    logic [N_CH-1:0][K-2:0]         addr_q, addr_d, addr_nxt;
    logic [K-1:0][DATA_WIDTH_B-1:0] bt_q, bt_d, bt_nxt;
    logic [LFSR_W-1:0]              alfsr_q, alfsr_d, alfsr_nxt;
    logic [LFSR_W-1:0]              blfsr_q, blfsr_d, blfsr_nxt;
    logic [GAP_W-1:0]               gap_q, gap_d;
    logic [BW-1:0]                  bcnt_q, bcnt_d, bcnt_inc;
    logic                           first_q, first_d;
    logic [15:0]                    vcnt_q, vcnt_d;
    logic                           done_q, done_d;
    logic                           upd_q, upd_d;
    logic                           accept, load, last;

`ifdef LFSR_STIM_GEN_CHKSUM_EN
    localparam int AW  = N_CH * (K - 1);
    localparam int NSL = (AW + 31) / 32;

    function automatic logic [31:0] fold32(input logic [AW-1:0] v);
        logic [NSL*32-1:0] pad;
        logic [31:0]       r;
        pad = '0;
        pad[AW-1:0] = v;
        r = '0;
        for (int i = 0; i < NSL; i++) r = r ^ pad[i*32 +: 32];
        return r;
    endfunction

    logic [31:0] cs_q, cs_d;
    assign checksum = cs_q;
`else
    assign checksum = '0;
`endif

    // Next address and weight vectors: many LFSR steps unrolled into one cycle.
    always_comb begin
        alfsr_nxt = alfsr_q;
        addr_nxt  = '0;
        for (int c = 0; c < N_CH; c++) begin
            for (int b = 0; b < K - 1; b++) begin
                alfsr_nxt      = lfsr_step(alfsr_nxt);
                addr_nxt[c][b] = alfsr_nxt[0];
            end
        end
        blfsr_nxt = blfsr_q;
        bt_nxt    = '0;
        for (int i = 0; i < K; i++) begin
            blfsr_nxt = lfsr_step(blfsr_nxt);
            bt_nxt[i] = blfsr_nxt[DATA_WIDTH_B-1:0];
        end
    end

    // Run control: seeding, vector loads, accept bookkeeping, completion and abort.
    always_comb begin
        state_d  = state_q;
        valid_d  = valid_q;
        addr_d   = addr_q;
        bt_d     = bt_q;
        alfsr_d  = alfsr_q;
        blfsr_d  = blfsr_q;
        gap_d    = gap_q;
        bcnt_d   = bcnt_q;
        bcnt_inc = bcnt_q;
        first_d  = first_q;
        vcnt_d   = vcnt_q;
        done_d   = 1'b0;
        upd_d    = 1'b0;
        load     = 1'b0;
        accept   = valid_q & out_ready;
        last     = (num_vectors != 16'd0) && (16'(vcnt_q + 16'd1) == num_vectors);
`ifdef LFSR_STIM_GEN_CHKSUM_EN
        cs_d     = cs_q;
`endif
        unique case (state_q)
            S_IDLE: begin
                // A zero seed would lock the LFSR, so fall back to the default.
                if (seed_load) begin
                    alfsr_d = (seed_addr == '0) ? SEED_ADDR_DEF : seed_addr;
                    blfsr_d = (seed_b == '0) ? SEED_B_DEF : seed_b;
                end
                if (start) begin
                    state_d = S_RUN;
                    vcnt_d  = '0;
                    gap_d   = '0;
                    bcnt_d  = '0;
                    first_d = 1'b1;
`ifdef LFSR_STIM_GEN_CHKSUM_EN
                    cs_d    = '0;
`endif
                end
            end
            S_RUN: begin
                if (accept) begin
                    vcnt_d   = vcnt_q + 16'd1;
                    bcnt_inc = bcnt_q + 1'b1;
                    bcnt_d   = bcnt_inc;
                    gap_d    = GAP_RELOAD;
                    valid_d  = 1'b0;
`ifdef LFSR_STIM_GEN_CHKSUM_EN
                    cs_d     = {cs_q[30:0], cs_q[31]} ^ fold32(addr_q);
`endif
                end
                if (stop) begin
                    state_d = S_IDLE;
                    valid_d = 1'b0;
                end else if (accept && last) begin
                    state_d = S_IDLE;
                    valid_d = 1'b0;
                    done_d  = 1'b1;
                end else if (accept) begin
                    load = (ADDR_UPDATE_PERIOD == 1);
                end else if (!valid_q) begin
                    if (gap_q == '0) load = 1'b1;
                    else             gap_d = gap_q - 1'b1;
                end
                if (load) begin
                    valid_d = 1'b1;
                    addr_d  = addr_nxt;
                    alfsr_d = alfsr_nxt;
                    if (first_q || bcnt_inc == B_PERIOD) begin
                        bt_d    = bt_nxt;
                        blfsr_d = blfsr_nxt;
                        upd_d   = 1'b1;
                        bcnt_d  = '0;
                        first_d = 1'b0;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State register; reset reverts both LFSRs to their default seeds.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            valid_q <= 1'b0;
            addr_q  <= '0;
            bt_q    <= '0;
            alfsr_q <= SEED_ADDR_DEF;
            blfsr_q <= SEED_B_DEF;
            gap_q   <= '0;
            bcnt_q  <= '0;
            first_q <= 1'b0;
            vcnt_q  <= '0;
            done_q  <= 1'b0;
            upd_q   <= 1'b0;
`ifdef LFSR_STIM_GEN_CHKSUM_EN
            cs_q    <= '0;
`endif
        end else begin
            state_q <= state_d;
            valid_q <= valid_d;
            addr_q  <= addr_d;
            bt_q    <= bt_d;
            alfsr_q <= alfsr_d;
            blfsr_q <= blfsr_d;
            gap_q   <= gap_d;
            bcnt_q  <= bcnt_d;
            first_q <= first_d;
            vcnt_q  <= vcnt_d;
            done_q  <= done_d;
            upd_q   <= upd_d;
`ifdef LFSR_STIM_GEN_CHKSUM_EN
            cs_q    <= cs_d;
`endif
        end
    end

    assign out_valid      = valid_q;
    assign addr_array     = addr_q;
    assign B_temp         = bt_q;
    assign update_pulse_b = upd_q;
    assign busy           = (state_q == S_RUN);
    assign done           = done_q;
    assign vec_count      = vcnt_q;

endmodule

// File: tb/tb_lfsr_stim_gen.sv
// tb_lfsr_stim_gen: directed checks of lfsr_stim_gen against a small LFSR model.
// Instance u_a uses P=1/B period 16; instance u_b uses P=3/B period 2.
module tb_lfsr_stim_gen;

    logic clk = 1'b0;
    logic rst, start_a, start_b, stop, seed_load, out_ready;
    logic [15:0] num_vectors, seed_addr, seed_b;

    logic               valid_a, upd_a, busy_a, done_a;
    logic [1:0][6:0]    addr_a;
    logic signed [7:0][7:0] bt_a;
    logic [15:0]        vc_a;
    logic [31:0]        cs_a;

    logic               valid_b, upd_b, busy_b, done_b;
    logic [1:0][6:0]    addr_b;
    logic signed [7:0][7:0] bt_b;
    logic [15:0]        vc_b;
    logic [31:0]        cs_b;

    int n_chk = 0;
    int n_pass = 0;

    logic [15:0] m_a, m_w;
    logic [13:0] ex_a;
    logic [63:0] ex_w;
    logic [31:0] exp_cs, cs1;

    always #5 clk = ~clk;

    lfsr_stim_gen u_a (
        .clk(clk), .rst(rst), .start(start_a), .stop(stop), .num_vectors(num_vectors),
        .seed_load(seed_load), .seed_addr(seed_addr), .seed_b(seed_b),
        .out_valid(valid_a), .out_ready(out_ready), .addr_array(addr_a), .B_temp(bt_a),
        .update_pulse_b(upd_a), .busy(busy_a), .done(done_a), .vec_count(vc_a),
        .checksum(cs_a)
    );

    lfsr_stim_gen #(.ADDR_UPDATE_PERIOD(3), .B_UPDATE_PERIOD(2)) u_b (
        .clk(clk), .rst(rst), .start(start_b), .stop(stop), .num_vectors(num_vectors),
        .seed_load(seed_load), .seed_addr(seed_addr), .seed_b(seed_b),
        .out_valid(valid_b), .out_ready(out_ready), .addr_array(addr_b), .B_temp(bt_b),
        .update_pulse_b(upd_b), .busy(busy_b), .done(done_b), .vec_count(vc_b),
        .checksum(cs_b)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        if (obs !== exp) $display("FAIL %s: got %h want %h", tag, obs, exp);
        else n_pass++;
    endtask

    function automatic logic [15:0] step(input logic [15:0] s);
        return {s[14:0], s[15] ^ s[13] ^ s[12] ^ s[10]};
    endfunction

    task automatic gen_addr(inout logic [15:0] s, output logic [13:0] v);
        for (int i = 0; i < 14; i++) begin
            s = step(s);
            v[i] = s[0];
        end
    endtask

    task automatic gen_w(inout logic [15:0] s, output logic [63:0] w);
        for (int i = 0; i < 8; i++) begin
            s = step(s);
            w[i*8 +: 8] = s[7:0];
        end
    endtask

    function automatic logic [31:0] cs_want();
`ifdef LFSR_STIM_GEN_CHKSUM_EN
        return exp_cs;
`else
        return 32'd0;
`endif
    endfunction

    // One presented vector on u_a; every such vector is eventually accepted.
    task automatic see_a(input logic refresh);
        gen_addr(m_a, ex_a);
        if (refresh) gen_w(m_w, ex_w);
        exp_cs = {exp_cs[30:0], exp_cs[31]} ^ {18'd0, ex_a};
        chk("valid", valid_a, 1);
        chk("addr", addr_a, ex_a);
        chk("b_temp", bt_a, ex_w);
        chk("upd_b", upd_a, refresh);
    endtask

    task automatic run_a(input int n);
        num_vectors = 16'(n);
        start_a = 1'b1;
        @(negedge clk);
        start_a = 1'b0;
        exp_cs = '0;
        chk("busy", busy_a, 1);
        chk("no_valid_first", valid_a, 0);
        for (int v = 1; v <= n; v++) begin
            @(negedge clk);
            see_a(v == 1);
        end
        @(negedge clk);
        chk("done", done_a, 1);
        chk("valid_end", valid_a, 0);
        chk("vec_count", vc_a, 64'(n));
        chk("busy_end", busy_a, 0);
        chk("checksum", cs_a, cs_want());
    endtask

    task automatic do_reset();
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        m_a = 16'hD348;
        m_w = 16'hA562;
        ex_w = '0;
        exp_cs = '0;
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_valid"}, valid_a, 0);
        chk({tag, "_addr"}, addr_a, 0);
        chk({tag, "_b"}, bt_a, 0);
        chk({tag, "_upd"}, upd_a, 0);
        chk({tag, "_busy"}, busy_a, 0);
        chk({tag, "_done"}, done_a, 0);
        chk({tag, "_vc"}, vc_a, 0);
        chk({tag, "_cs"}, cs_a, 0);
    endtask

    initial begin
        logic [15:0] lb_a, lb_w;
        logic [13:0] eb_a;
        logic [63:0] eb_w;

        rst = 1'b1; start_a = 0; start_b = 0; stop = 0; seed_load = 0;
        out_ready = 1'b1; num_vectors = '0; seed_addr = '0; seed_b = '0;
        @(negedge clk);
        chk_zero("rst");
        do_reset();

        // Test 1: five vectors back to back from the default seeds.
        run_a(5);
        @(negedge clk);
        chk("done_once", done_a, 0);
        cs1 = cs_want();

        // Test 2: P=3, weight refresh every 2 accepted vectors.
        do_reset();
        lb_a = 16'hD348; lb_w = 16'hA562; eb_w = '0;
        num_vectors = 16'd6;
        start_b = 1'b1;
        @(negedge clk);
        start_b = 1'b0;
        chk("b_busy", busy_b, 1);
        for (int v = 1; v <= 6; v++) begin
            @(negedge clk);
            gen_addr(lb_a, eb_a);
            if (v % 2 == 1) gen_w(lb_w, eb_w);
            chk("b_valid", valid_b, 1);
            chk("b_addr", addr_b, eb_a);
            chk("b_btemp", bt_b, eb_w);
            chk("b_upd", upd_b, (v % 2 == 1));
            if (v < 6) begin
                for (int g = 0; g < 2; g++) begin
                    @(negedge clk);
                    chk("b_gap", valid_b, 0);
                end
            end
        end
        @(negedge clk);
        chk("b_done", done_b, 1);
        chk("b_vc", vc_b, 6);

        // Test 3: four cycles of backpressure on vector 2.
        num_vectors = 16'd5;
        start_a = 1'b1;
        @(negedge clk);
        start_a = 1'b0;
        exp_cs = '0;
        chk("bp_busy", busy_a, 1);
        @(negedge clk); see_a(1'b1);
        @(negedge clk); see_a(1'b0);
        out_ready = 1'b0;
        for (int s = 0; s < 4; s++) begin
            @(negedge clk);
            chk("bp_valid", valid_a, 1);
            chk("bp_addr_hold", addr_a, ex_a);
            chk("bp_b_hold", bt_a, ex_w);
            chk("bp_vc", vc_a, 1);
        end
        out_ready = 1'b1;
        for (int v = 3; v <= 5; v++) begin
            @(negedge clk);
            see_a(1'b0);
        end
        @(negedge clk);
        chk("bp_done", done_a, 1);
        chk("bp_vc_end", vc_a, 5);

        // Test 4: zero address seed falls back to default; start in the same cycle.
        seed_load = 1'b1; seed_addr = 16'h0000; seed_b = 16'h1234;
        num_vectors = 16'd3;
        start_a = 1'b1;
        @(negedge clk);
        seed_load = 1'b0; start_a = 1'b0;
        m_a = 16'hD348; m_w = 16'h1234; exp_cs = '0;
        chk("sd_busy", busy_a, 1);
        @(negedge clk); see_a(1'b1);
        // start and seed_load while running must be ignored
        start_a = 1'b1; seed_load = 1'b1; seed_addr = 16'hFFFF; seed_b = 16'hFFFF;
        @(negedge clk); see_a(1'b0);
        start_a = 1'b0; seed_load = 1'b0;
        @(negedge clk); see_a(1'b0);
        @(negedge clk);
        chk("sd_done", done_a, 1);
        chk("sd_vc", vc_a, 3);

        // Test 5: stop on the third accept of five.
        num_vectors = 16'd5;
        start_a = 1'b1;
        @(negedge clk);
        start_a = 1'b0;
        exp_cs = '0;
        @(negedge clk); see_a(1'b1);
        @(negedge clk); see_a(1'b0);
        @(negedge clk); see_a(1'b0);
        stop = 1'b1;
        @(negedge clk);
        stop = 1'b0;
        chk("stop_busy", busy_a, 0);
        chk("stop_valid", valid_a, 0);
        chk("stop_vc", vc_a, 3);
        chk("stop_no_done", done_a, 0);
        @(negedge clk);
        chk("stop_no_done2", done_a, 0);
        run_a(2);

        // Test 6: asynchronous reset mid-run, then the first run reproduced.
        do_reset();
        run_a(5);
        chk("cs_repeat", cs_want(), cs1);
        num_vectors = 16'd5;
        start_a = 1'b1;
        @(negedge clk);
        start_a = 1'b0;
        exp_cs = '0;
        @(negedge clk); see_a(1'b1);
        @(negedge clk); see_a(1'b0);
        #2 rst = 1'b1;
        #1 chk_zero("async_rst");
        @(negedge clk);
        rst = 1'b0;
        m_a = 16'hD348; m_w = 16'hA562; ex_w = '0; exp_cs = '0;
        run_a(5);
        chk("cs_after_rst", cs_a, cs1);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
